// File: rtl/jx2_cssub_pkg.sv
// Shared constants and types for the 64-bit carry-select subtractor.
package jx2_cssub_pkg;
    localparam int SEG_W  = 16;
    localparam int SEG_N  = 4;
    localparam int DATA_W = SEG_W * SEG_N;
    localparam int STAGES = 2;

    typedef logic [SEG_W:0] seg_sum_t;
endpackage

// File: rtl/jx2_cs_seg17.sv
// One carry-select segment: both candidate 17-bit sums, for carry-in 0 and carry-in 1.
module jx2_cs_seg17
    import jx2_cssub_pkg::*;
(
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    output seg_sum_t         sum0,
    output seg_sum_t         sum1
);
    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + seg_sum_t'(1);
endmodule

// File: rtl/jx2_ex_cs_sub64p.sv
// Two-stage 64-bit subtractor: segment sum pairs in stage 1, carry ripple-select
// and compare flags in stage 2.
module jx2_ex_cs_sub64p
    import jx2_cssub_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        inValid,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    output logic        outValid,
    output logic [63:0] valC,
    output logic        outBorrow,
    output logic        outZero,
    output logic        outSLt,
    output logic        outOvf
);
    if (SEG_W != jx2_cssub_pkg::SEG_W) begin : g_bad_seg_w
        $error("jx2_ex_cs_sub64p: only SEG_W=16 is supported");
    end

    logic [63:0] b_n;
    seg_sum_t    seg0_d;
    seg_sum_t    sum0_d [1:SEG_N-1];
    seg_sum_t    sum1_d [1:SEG_N-1];

    // A - B as A + ~B + 1; the +1 enters only at segment 0.
    assign b_n    = ~valB;
    assign seg0_d = {1'b0, valA[SEG_W-1:0]} + {1'b0, b_n[SEG_W-1:0]} + seg_sum_t'(1);

    for (genvar i = 1; i < SEG_N; i++) begin : g_seg
        jx2_cs_seg17 u_seg (
            .a    (valA[i*SEG_W +: SEG_W]),
            .b    (b_n[i*SEG_W +: SEG_W]),
            .sum0 (sum0_d[i]),
            .sum1 (sum1_d[i])
        );
    end

    seg_sum_t          seg0_q;
    seg_sum_t          sum0_q [1:SEG_N-1];
    seg_sum_t          sum1_q [1:SEG_N-1];
    logic              a63_q;
    logic              b63_q;
    logic [STAGES-1:0] vld_pipe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg0_q <= '0;
            a63_q  <= 1'b0;
            b63_q  <= 1'b0;
            for (int i = 1; i < SEG_N; i++) begin
                sum0_q[i] <= '0;
                sum1_q[i] <= '0;
            end
        end else if (!hold) begin
            seg0_q <= seg0_d;
            a63_q  <= valA[63];
            b63_q  <= valB[63];
            for (int i = 1; i < SEG_N; i++) begin
                sum0_q[i] <= sum0_d[i];
                sum1_q[i] <= sum1_d[i];
            end
        end
    end

    logic [63:0] res;
    logic        cout;
    logic        carry;
    seg_sum_t    sel;
    logic        ovf;

    // Each segment's selected carry-out picks the next segment's candidate.
    always_comb begin
        res   = '0;
        sel   = '0;
        carry = seg0_q[SEG_W];
        res[SEG_W-1:0] = seg0_q[SEG_W-1:0];
        for (int i = 1; i < SEG_N; i++) begin
            sel   = carry ? sum1_q[i] : sum0_q[i];
            res[i*SEG_W +: SEG_W] = sel[SEG_W-1:0];
            carry = sel[SEG_W];
        end
        cout = carry;
        ovf  = (a63_q != b63_q) && (res[63] != a63_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            valC      <= '0;
            outBorrow <= 1'b0;
            outZero   <= 1'b0;
            outSLt    <= 1'b0;
            outOvf    <= 1'b0;
        end else if (!hold) begin
            vld_pipe  <= {vld_pipe[STAGES-2:0], inValid};
            valC      <= res;
            outBorrow <= ~cout;
            outZero   <= (res == 64'd0);
            outSLt    <= res[63] ^ ovf;
            outOvf    <= ovf;
        end
    end

    assign outValid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_jx2_ex_cs_sub64p.sv
// Directed self-checking bench for jx2_ex_cs_sub64p.
module tb_jx2_ex_cs_sub64p;
    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        inValid;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        outValid;
    logic [63:0] valC;
    logic        outBorrow;
    logic        outZero;
    logic        outSLt;
    logic        outOvf;

    int checks = 0;
    int errors = 0;

    jx2_ex_cs_sub64p #(.SEG_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .inValid   (inValid),
        .valA      (valA),
        .valB      (valB),
        .outValid  (outValid),
        .valC      (valC),
        .outBorrow (outBorrow),
        .outZero   (outZero),
        .outSLt    (outSLt),
        .outOvf    (outOvf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // flags packed as {borrow, zero, slt, ovf}
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_c, input logic [3:0] exp_f);
        valA = a; valB = b; inValid = 1'b1;
        tick();
        inValid = 1'b0; valA = ~a; valB = a;
        chk({tag, ".v1"}, 64'(outValid), 64'd0);
        tick();
        chk({tag, ".v2"}, 64'(outValid), 64'd1);
        chk({tag, ".c"}, valC, exp_c);
        chk({tag, ".f"}, 64'({outBorrow, outZero, outSLt, outOvf}), 64'(exp_f));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] c);
        chk({tag, ".v"}, 64'(outValid), 64'(v));
        if (v) chk({tag, ".c"}, valC, c);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; inValid = 1'b0; valA = '0; valB = '0;
        #2;
        chk("rst.c", valC, 64'd0);
        chk("rst.f", 64'({outValid, outBorrow, outZero, outSLt, outOvf}), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        run_op("s1",   64'd5, 64'd3, 64'd2, 4'b0000);
        run_op("s2",   64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);
        run_op("s3",   64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
        run_op("s4",   64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 4'b0000);
        run_op("zero", 64'd0, 64'd0, 64'd0, 4'b0100);
        run_op("b16",  64'h0000_0000_0001_0000, 64'd1, 64'h0000_0000_0000_FFFF, 4'b0000);
        run_op("b48",  64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 4'b0000);
        run_op("ovfn", 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 4'b1001);
        run_op("eq",   64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 4'b0100);
        run_op("neg",  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 4'b1010);

        // stream of 4 with a 3-cycle hold after the second operand is sampled
        valA = 64'd10; valB = 64'd3; inValid = 1'b1;
        tick();
        valA = 64'd100; valB = 64'd1;
        tick();
        chk_out("st.op0", 1'b1, 64'd7);
        valA = 64'd0; valB = 64'd5; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("st.hold", 1'b1, 64'd7);
        end
        hold = 1'b0;
        tick();
        chk_out("st.op1", 1'b1, 64'd99);
        valA = 64'h20; valB = 64'h20;
        tick();
        chk_out("st.op2", 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        inValid = 1'b0;
        tick();
        chk_out("st.op3", 1'b1, 64'd0);
        chk("st.z", 64'(outZero), 64'd1);
        tick();
        chk_out("st.end", 1'b0, 64'd0);

        // reset with two operations in flight, asserted off the clock edge
        valA = 64'd9; valB = 64'd4; inValid = 1'b1;
        tick();
        valA = 64'd8; valB = 64'd2;
        tick();
        chk_out("rf.pre", 1'b1, 64'd5);
        inValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rf.c", valC, 64'd0);
        chk("rf.f", 64'({outValid, outBorrow, outZero, outSLt, outOvf}), 64'd0);
        hold = 1'b1;
        tick();
        chk("rf.hold", 64'({outValid, outBorrow, outZero, outSLt, outOvf}), 64'd0);
        hold = 1'b0;
        #3 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("rf.stale", 1'b0, 64'd0);
        end
        run_op("rf.after", 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jx2_ex_cs_sub64p.md
JX2_EX_CS_SUB64P -- requirements
Module: jx2_ex_cs_sub64p

Interface
REQ-001 Parameter: SEG_W, default 16, carry-select segment width; only 16 is supported and elaboration SHALL fail for any other value.
REQ-002 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: hold  in  1  pipeline stall; when high, all pipeline registers SHALL keep their values.
REQ-005 Port: inValid  in  1  operand pair on valA/valB is valid this cycle.
REQ-006 Port: valA  in  64  minuend.
REQ-007 Port: valB  in  64  subtrahend.
REQ-008 Port: outValid  out  1  result outputs are valid.
REQ-009 Port: valC  out  64  difference valA - valB, modulo 2^64.
REQ-010 Port: outBorrow  out  1  unsigned valA < valB.
REQ-011 Port: outZero  out  1  valC == 0, i.e. valA == valB.
REQ-012 Port: outSLt  out  1  signed valA < valB.
REQ-013 Port: outOvf  out  1  signed overflow of the subtraction.

Function
REQ-014 Arithmetic SHALL be valC = valA + ~valB + 1, computed as four 16-bit segments; carry-out of bit 63 = Cout.
REQ-015 Stage 1 (registered on a clock edge with hold=0):
- segment 0: 17-bit sum with carry-in 1.
- segments 1..3: two 17-bit sums each, one with carry-in 0 and one with carry-in 1.
- valA[63], valB[63] and inValid are also registered.
REQ-016 Stage 2 (next clock edge with hold=0):
- each selected segment's carry picks the next segment's sum, ripple from segment 0 to segment 3.
- valC, flags and outValid are registered from that selection.
REQ-017 Latency SHALL be exactly 2 non-held clock edges from operand sample to outValid/valC; throughput is one operation per non-held cycle.
REQ-018 Flags SHALL be:
- outBorrow = ~Cout.
- outZero = (valC == 0).
- outOvf = (A63 != B63) & (C63 != A63).
- outSLt = C63 ^ outOvf.
REQ-019 outValid SHALL follow the registered inValid through both stages; with inValid=0, stage data SHALL still update, but outValid=0 marks the outputs don't-care.
REQ-020 hold=1 SHALL freeze both stages and all outputs, including outValid, for as long as it is asserted; on release the pipeline SHALL resume with no loss or duplication of operations.
REQ-021 Simultaneous hold=1 and inValid=1: the input SHALL NOT be sampled; the upstream stage holds its operands stable.
REQ-022 Boundary results SHALL be exact:
- 0-0 gives Cout=1, outBorrow=0.
- 0-1 gives 0xFFFF_FFFF_FFFF_FFFF, outBorrow=1.
- The carry SHALL propagate across all segment boundaries (bits 15/16, 31/32, 47/48).

Reset
REQ-023 While reset=1, all stage registers, valC, outValid and all flags SHALL be 0, regardless of the clock edge or hold.
REQ-024 Reset asserted mid-operation SHALL discard in-flight operations; after deassertion, outValid SHALL stay 0 until 2 non-held edges after the next inValid=1.

Structure
REQ-025 The shared package jx2_cssub_pkg SHALL hold the SEG_W and segment-count constants and the 17-bit segment-sum typedef.
REQ-026 One sub-module, jx2_cs_seg17, SHALL compute the 17-bit carry-0/carry-1 sum pair for one segment; it SHALL be instanced 3 times, and segment 0 SHALL use carry-in 1 only.
REQ-027 Selection and flag logic SHALL be combinational between the stage-1 and stage-2 registers; no other state exists.

Verification
REQ-028 Directed scenario 1:
- stimulus: A=5, B=3.
- required response: valC=2, borrow=0, zero=0, slt=0, ovf=0, outValid high exactly 2 edges later.
REQ-029 Directed scenario 2:
- stimulus: A=0, B=1.
- required response: valC=0xFFFF_FFFF_FFFF_FFFF, borrow=1, slt=1, ovf=0.
REQ-030 Directed scenario 3:
- stimulus: A=0x8000_0000_0000_0000, B=1.
- required response: valC=0x7FFF_FFFF_FFFF_FFFF, ovf=1, slt=1, borrow=0.
REQ-031 Directed scenario 4:
- stimulus: A=0x0000_0001_0000_0000, B=0x0000_0000_0000_0001.
- required response: valC=0x0000_0000_FFFF_FFFF, exercising the borrow ripple through segment boundaries 1/2.
REQ-032 Directed scenario 5:
- stimulus: back-to-back stream of 4 operations, with hold=1 for 3 cycles inserted mid-stream.
- required response: outputs frozen for those 3 cycles; all 4 results appear in order, once each.
REQ-033 Directed scenario 6:
- stimulus: reset pulse with 2 operations in flight, including a reset edge that is not aligned to the clock.
- required response: outputs 0 immediately; no stale result is emitted after reset.
